// File: rtl/cpu_step_ctrl.sv
// Run/step/halt gate for the divided CPU clock: turns slow_clk rising edges into
// single-cycle cpu_en pulses in the main_clk domain and counts the issued ticks.
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 16
) (
   input  logic             main_clk,
   input  logic             reset,
   input  logic             slow_clk,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             halt_req,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] tick_count,
   output logic             halted
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] STEP_ARM = 2'd2;
   localparam logic [1:0] HALTED   = 2'd3;

   logic            s1, s2, s3;
   logic            r1, run_s;
   logic            b1, b2;
   logic [DB_W-1:0] db_cnt;
   logic            btn_db, btn_db_q;
   logic            rise, step_press;
   logic [1:0]      next_state;
   logic            pulse;

   // slow_clk and run_sw are asynchronous levels; the third slow_clk flop gives edge history
   always_ff @(posedge main_clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         r1    <= 1'b0;
         run_s <= 1'b0;
         b1    <= 1'b0;
         b2    <= 1'b0;
      end else begin
         s1    <= slow_clk;
         s2    <= s1;
         s3    <= s2;
         r1    <= run_sw;
         run_s <= r1;
         b1    <= step_btn;
         b2    <= b1;
      end
   end

   assign rise = s2 & ~s3;

   // A level change is accepted only after it persists for DEBOUNCE_CYCLES cycles
   always_ff @(posedge main_clk) begin
      if (reset) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
      end else begin
         btn_db_q <= btn_db;
         if (b2 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LIMIT) begin
            btn_db <= ~btn_db;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign step_press = btn_db & ~btn_db_q;

   always_comb begin
      next_state = state;
      pulse      = 1'b0;
      case (state)
         IDLE: begin
            if (halt_req)        next_state = HALTED;
            else if (run_s)      next_state = RUN;
            else if (step_press) next_state = STEP_ARM;
         end
         RUN: begin
            if (halt_req)        next_state = HALTED;
            else if (!run_s)     next_state = IDLE;
            else                 pulse      = rise;
         end
         STEP_ARM: begin
            if (halt_req) begin
               next_state = HALTED;
            end else if (rise) begin
               pulse      = 1'b1;
               next_state = IDLE;
            end
         end
         HALTED: next_state = HALTED;
      endcase
   end

   // Halted is sticky; only reset brings the controller back to IDLE
   always_ff @(posedge main_clk) begin
      if (reset) begin
         state      <= IDLE;
         cpu_en     <= 1'b0;
         tick_count <= '0;
      end else begin
         state  <= next_state;
         cpu_en <= pulse;
         if (pulse) tick_count <= tick_count + CNT_W'(1);
      end
   end

   assign halted = (state == HALTED);

endmodule
